// File: rtl/conv_stream_param.sv
// conv_stream_param: streaming 1-D valid-window convolution, one MAC per cycle.
// Define CONV_RELU_EN to clamp negative results to zero.
module conv_stream_param #(
  parameter int N  = 112,
  parameter int M  = 49,
  parameter int DW = 10,
  localparam int YW = 2*DW + $clog2(M)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] x_data,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic signed [DW-1:0] f_data,
  input  logic                 f_valid,
  output logic                 f_ready,
  input  logic                 f_reuse,
  output logic signed [YW-1:0] y_data,
  output logic                 y_valid,
  input  logic                 y_ready
);

  localparam int IW  = $clog2(N+1);
  localparam int JW  = $clog2(M+1);
  localparam int XAW = (N > 1) ? $clog2(N) : 1;
  localparam int FAW = (M > 1) ? $clog2(M) : 1;
  localparam logic [IW-1:0] N_C    = IW'(N);
  localparam logic [IW-1:0] K_LAST = IW'(N-M);
  localparam logic [JW-1:0] M_C    = JW'(M);
  localparam logic [JW-1:0] J_LAST = JW'(M-1);

  typedef enum logic [1:0] {LOAD, COMPUTE, OUT} state_t;
  state_t state, state_nxt;

  logic signed [DW-1:0] x_mem [N];
  logic signed [DW-1:0] f_mem [M];

  logic [IW-1:0] x_cnt, k, idx;
  logic [JW-1:0] f_cnt, j;
  logic f_loaded;
  logic signed [DW-1:0] xv, fv;
  logic signed [2*DW-1:0] prod;
  logic signed [YW-1:0] acc, sum, res;
  logic x_fire, f_fire, y_fire;
  logic load_done, last_mac, last_k;

  assign x_fire = x_valid && x_ready;
  assign f_fire = f_valid && f_ready;
  assign y_fire = y_valid && y_ready;

  assign load_done = (x_cnt == N_C)
                  && (f_loaded || f_cnt == M_C);
  assign last_mac  = (j == J_LAST);
  assign last_k    = (k == K_LAST);

  assign idx  = k + IW'(j);
  assign xv   = x_mem[XAW'(idx)];
  assign fv   = f_mem[FAW'(j)];
  assign prod = (2*DW)'(xv) * (2*DW)'(fv);
  assign sum  = acc + YW'(prod);

`ifdef CONV_RELU_EN
  assign res = sum[YW-1] ? '0 : sum;
`else
  assign res = sum;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  // Readies are held low while reset is asserted.
  always_comb begin
    state_nxt = state;
    x_ready   = 1'b0;
    f_ready   = 1'b0;
    unique case (state)
      LOAD: begin
        x_ready = !reset && (x_cnt < N_C);
        f_ready = !reset && !f_loaded && (f_cnt < M_C);
        if (load_done) state_nxt = COMPUTE;
      end
      COMPUTE: if (last_mac) state_nxt = OUT;
      OUT: if (y_fire) state_nxt = last_k ? LOAD : COMPUTE;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (x_fire) x_mem[XAW'(x_cnt)] <= x_data;
    if (f_fire) f_mem[FAW'(f_cnt)] <= f_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt    <= '0;
      f_cnt    <= '0;
      k        <= '0;
      j        <= '0;
      f_loaded <= 1'b0;
      acc      <= '0;
      y_data   <= '0;
      y_valid  <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (x_fire) x_cnt <= x_cnt + 1'b1;
          if (f_fire) f_cnt <= f_cnt + 1'b1;
          if (load_done) begin
            f_loaded <= 1'b1;
            k        <= '0;
            j        <= '0;
            acc      <= '0;
          end
        end
        COMPUTE: begin
          if (last_mac) begin
            y_data  <= res;
            y_valid <= 1'b1;
          end else begin
            acc <= sum;
            j   <= j + 1'b1;
          end
        end
        OUT: begin
          if (y_fire) begin
            y_valid <= 1'b0;
            j       <= '0;
            acc     <= '0;
            if (last_k) begin
              x_cnt <= '0;
              if (!f_reuse) begin
                f_cnt    <= '0;
                f_loaded <= 1'b0;
              end
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
